// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer output stage.
package fc_pkg;

    // Default geometry of the classifier head.
    localparam int FC_WORD_SIZE   = 16;
    localparam int FC_IDX_SIZE    = 4;
    localparam int FC_NUM_CLASSES = 10;

    // Argmax sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

endpackage : fc_pkg

// File: rtl/fc_argmax_sequencer_comparator.sv
// Two-input max comparator shared by the FC stage. Returns the larger
// operand with its index. X2 is kept on ties, so when X2 is the running
// maximum the earliest class index survives equal scores.
module Comparator #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_SIZE  = 4
) (
    input  logic [WORD_SIZE-1:0] X1,
    input  logic [IDX_SIZE-1:0]  indexX1,
    input  logic [WORD_SIZE-1:0] X2,
    input  logic [IDX_SIZE-1:0]  indexX2,
    output logic [WORD_SIZE-1:0] Y,
    output logic [IDX_SIZE-1:0]  indexY
);

    // Unsigned strict-greater select; X1 only wins when strictly larger.
    always_comb begin
        if (X1 > X2) begin
            Y      = X1;
            indexY = indexX1;
        end else begin
            Y      = X2;
            indexY = indexX2;
        end
    end

endmodule : Comparator

// File: rtl/fc_argmax_sequencer.sv
// Running-maximum scan over the FC score stream. Accepts NUM_CLASSES
// scores, one per handshake, and presents the winning score and class
// index on a ready/valid result port.
module fc_argmax_sequencer
    import fc_pkg::*;
#(
    parameter int WORD_SIZE   = FC_WORD_SIZE,
    parameter int IDX_SIZE    = FC_IDX_SIZE,
    parameter int NUM_CLASSES = FC_NUM_CLASSES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] max_val,
    output logic [IDX_SIZE-1:0]  max_idx,
    output logic                 busy
);

    // Index of the final beat; the scan ends here so cnt never wraps.
    localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(NUM_CLASSES - 1);

    argmax_state_t        state_q, state_d;
    logic [IDX_SIZE-1:0]  cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] max_val_q, max_val_d;
    logic [IDX_SIZE-1:0]  max_idx_q, max_idx_d;

    logic [WORD_SIZE-1:0] cmp_val;
    logic [IDX_SIZE-1:0]  cmp_idx;
    logic                 beat;

    // New score on X1 against the running maximum on X2.
    Comparator #(
        .WORD_SIZE (WORD_SIZE),
        .IDX_SIZE  (IDX_SIZE)
    ) u_cmp (
        .X1      (in_data),
        .indexX1 (cnt_q),
        .X2      (max_val_q),
        .indexX2 (max_idx_q),
        .Y       (cmp_val),
        .indexY  (cmp_idx)
    );

    // Handshake outputs decode straight from state, so there is no
    // combinational path from in_valid/out_ready back to ready/valid.
    assign in_ready  = (state_q == SCAN);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign max_val   = max_val_q;
    assign max_idx   = max_idx_q;
    assign beat      = in_valid & in_ready;

    // Next-state, beat counter and result register update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (beat) begin
                    // First beat seeds the maximum; later beats go through
                    // the comparator.
                    if (cnt_q == '0) begin
                        max_val_d = in_data;
                        max_idx_d = '0;
                    end else begin
                        max_val_d = cmp_val;
                        max_idx_d = cmp_idx;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + IDX_SIZE'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

endmodule : fc_argmax_sequencer

// File: tb/tb_fc_argmax_sequencer.sv
// Directed bench for fc_argmax_sequencer with hand-computed results.
module tb_fc_argmax_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] max_val;
    logic [3:0]  max_idx;
    logic        busy;

    int          n_checks;
    int          n_fail;
    int          cyc;
    logic [15:0] vec [10];

    fc_argmax_sequencer #(
        .WORD_SIZE   (16),
        .IDX_SIZE    (4),
        .NUM_CLASSES (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_val   (max_val),
        .max_idx   (max_idx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Feed the ten scores in vec; optional random gaps. Returns gap count.
    task automatic feed_beats(input bit stall, output int gaps);
        gaps = 0;
        for (int i = 0; i < 10; i++) begin
            if (stall) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    in_data  = 16'hDEAD;
                    @(negedge clk);
                    gaps++;
                end
            end
            in_valid = 1'b1;
            in_data  = vec[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Start a scan at the current negedge, feed it, wait for out_valid.
    task automatic do_scan(input bit stall, output int lat, output int gaps, output bit tmo);
        int t0;
        int n;
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        feed_beats(stall, gaps);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        tmo = (n >= 50);
        lat = cyc - t0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 0 0 0", in_ready, out_valid, busy);
        end
        n_checks++;
        if (max_val !== 16'd0 || max_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_result: max_val=%0d max_idx=%0d, required 0 0", max_val, max_idx);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Shared result check: compares latency and result, then hands off.
    task automatic check_and_take(input string nm, input int lat, input int exp_lat,
                                  input bit tmo, input logic [15:0] ev, input logic [3:0] ei);
        n_checks++;
        if (tmo || out_valid !== 1'b1 || lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: out_valid=%b latency=%0d, required 1 after %0d cycles", nm, out_valid, lat, exp_lat);
        end
        n_checks++;
        if (max_val !== ev || max_idx !== ei) begin
            n_fail++;
            $display("FAIL %s_result: max_val=%h max_idx=%0d, required %h %0d", nm, max_val, max_idx, ev, ei);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || max_val !== ev || max_idx !== ei) begin
            n_fail++;
            $display("FAIL %s_handoff: busy=%b out_valid=%b max_val=%h, required 0 0 %h", nm, busy, out_valid, max_val, ev);
        end
        $display("scan %s: max_val=%h max_idx=%0d latency=%0d", nm, max_val, max_idx, lat);
    endtask

    task automatic load_basic();
        vec[0] = 3; vec[1] = 9; vec[2] = 1; vec[3] = 7; vec[4] = 2;
        vec[5] = 8; vec[6] = 0; vec[7] = 5; vec[8] = 4; vec[9] = 6;
    endtask

    task automatic test_basic();
        int lat, gaps;
        bit tmo;
        load_basic();
        do_scan(1'b0, lat, gaps, tmo);
        check_and_take("basic", lat, 11, tmo, 16'd9, 4'd1);
    endtask

    task automatic test_tie();
        int lat, gaps;
        bit tmo;
        vec[0] = 5; vec[1] = 12; vec[2] = 4; vec[3] = 12; vec[4] = 0;
        vec[5] = 0; vec[6] = 0;  vec[7] = 0; vec[8] = 0;  vec[9] = 12;
        do_scan(1'b0, lat, gaps, tmo);
        check_and_take("tie", lat, 11, tmo, 16'd12, 4'd1);
    endtask

    task automatic test_extremes();
        int lat, gaps;
        bit tmo;
        for (int i = 0; i < 10; i++) vec[i] = 16'd0;
        do_scan(1'b0, lat, gaps, tmo);
        check_and_take("zeros", lat, 11, tmo, 16'd0, 4'd0);
        for (int i = 0; i < 9; i++) vec[i] = 16'hFFFE - 16'(i);
        vec[9] = 16'hFFFF;
        do_scan(1'b0, lat, gaps, tmo);
        check_and_take("maxval", lat, 11, tmo, 16'hFFFF, 4'd9);
    endtask

    task automatic test_stalls();
        int lat, gaps;
        bit tmo;
        for (int r = 0; r < 2; r++) begin
            load_basic();
            do_scan(1'b1, lat, gaps, tmo);
            check_and_take("stall", lat, 11 + gaps, tmo, 16'd9, 4'd1);
        end
    endtask

    task automatic test_backpressure();
        int lat, gaps;
        bit tmo;
        vec[0] = 100; vec[1] = 50; vec[2] = 300; vec[3] = 299; vec[4] = 7;
        vec[5] = 301; vec[6] = 2;  vec[7] = 300; vec[8] = 0;   vec[9] = 1;
        do_scan(1'b0, lat, gaps, tmo);
        for (int k = 0; k < 5; k++) begin
            start = k[0];
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 ||
                max_val !== 16'd301 || max_idx !== 4'd5) begin
                n_fail++;
                $display("FAIL hold_done_%0d: out_valid=%b busy=%b in_ready=%b max_val=%0d max_idx=%0d, required 1 1 0 301 5",
                         k, out_valid, busy, in_ready, max_val, max_idx);
            end
        end
        start = 1'b0;
        check_and_take("backpressure", lat, 11, tmo, 16'd301, 4'd5);
    endtask

    task automatic test_reset_mid_scan();
        int lat, gaps;
        bit tmo;
        vec[0] = 40; vec[1] = 41; vec[2] = 42; vec[3] = 43;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || max_val !== 16'd0 || max_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b out_valid=%b in_ready=%b max_val=%0d max_idx=%0d, required 0 0 0 0 0",
                     busy, out_valid, in_ready, max_val, max_idx);
        end
        $display("mid-scan reset: busy=%b max_val=%0d", busy, max_val);
        load_basic();
        vec[7] = 20;
        do_scan(1'b0, lat, gaps, tmo);
        check_and_take("after_reset", lat, 11, tmo, 16'd20, 4'd7);
    endtask

    task automatic test_back_to_back();
        int lat, gaps;
        bit tmo;
        load_basic();
        do_scan(1'b0, lat, gaps, tmo);
        check_and_take("b2b_first", lat, 11, tmo, 16'd9, 4'd1);
        // Now in the first IDLE cycle after handoff: start immediately.
        vec[0] = 10; vec[1] = 20; vec[2] = 30;       vec[3] = 40; vec[4] = 50;
        vec[5] = 60; vec[6] = 16'h1234; vec[7] = 7;  vec[8] = 8;  vec[9] = 16'h1233;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b in_ready=%b, required 1 1", busy, in_ready);
        end
        feed_beats(1'b0, gaps);
        n_checks++;
        if (out_valid !== 1'b1 || max_val !== 16'h1234 || max_idx !== 4'd6) begin
            n_fail++;
            $display("FAIL b2b_second: out_valid=%b max_val=%h max_idx=%0d, required 1 1234 6", out_valid, max_val, max_idx);
        end
        $display("scan b2b_second: max_val=%h max_idx=%0d", max_val, max_idx);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_handoff: busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_tie();
        test_extremes();
        test_stalls();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fc_argmax_sequencer
